gates_tester: RTL and testbench
===============================

Name: gates_tester

Overview:
- Self-checking stimulus and response stage that wraps the primitive gate block.
- Drives a_i/b_i/ctrl_i of the gate block from its own a_o/b_o/ctrl_o, walking all 8 (a,b,ctrl) combinations.
- Samples the gate block's 12 outputs as one bus, compares them against a built-in truth table, and reports a pass/fail summary.
- Used for on-board bring-up and as a reusable bench component.

Parameters:
- SETTLE_CYCLES, 2, cycles between a new vector appearing on a_o/b_o/ctrl_o and its sampling; legal range 1..15.
- LOOPS, 1, number of full passes through the 8 vectors; legal range 1..255.
- ERR_CNT_W, 4, width of the saturating error counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a run; sampled only in IDLE.
- obs_i  in  12  observed gate outputs, bit order: 0 and, 1 or, 2 xor, 3 nand, 4 nor, 5 xnor, 6 not_a, 7 buf_a, 8 bufif0, 9 notif0, 10 bufif1, 11 notif1.
- a_o  out  1  stimulus a, equal to vec[2].
- b_o  out  1  stimulus b, equal to vec[1].
- ctrl_o  out  1  stimulus ctrl, equal to vec[0].
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  1  err_cnt_o==0 at end of run; held until the next start.
- err_cnt_o  out  ERR_CNT_W  count of failing vectors, saturating.
- fail_mask_o  out  12  sticky OR of mismatching bits over the run.

Behaviour:
- Reset (rst_i high at a clock edge): all outputs 0, vec=0, loop=0, state IDLE.
  - Reset mid-run aborts the run immediately.
  - No done_o pulse is produced for an aborted run.
- All outputs are registered; a_o/b_o/ctrl_o always reflect vec.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start_i=1 -> vec=0, loop=0, err_cnt=0, fail_mask=0, pass_o=0, settle counter=0 -> SETTLE.
  - start_i is ignored in every state other than IDLE.
- SETTLE: counts SETTLE_CYCLES cycles, then -> SAMPLE.
- SAMPLE (1 cycle):
  - Compare obs_i against the expected value for vec.
  - Only enabled bits are compared: bits 8/9 only when ctrl=0, bits 10/11 only when ctrl=1. Tri-state bits in their disabled state are masked.
  - Any masked-in mismatch: err_cnt +1 (saturates at 2^ERR_CNT_W-1); fail_mask |= mismatch bits.
  - At most one increment per vector, regardless of how many bits mismatch.
  - Next state:
    - vec==7 and loop==LOOPS-1 -> DONE.
    - vec==7 otherwise -> vec wraps to 0, loop+1, -> SETTLE.
    - else vec+1 -> SETTLE.
- Expected values: and=a&b, or=a|b, xor=a^b, nand, nor, xnor=~(a^b), not_a=~a, buf_a=a, bufif0=a, notif0=~a, bufif1=a, notif1=~a.
- Non-0/1 values on compared bits count as mismatches (4-state compare in simulation).
- DONE (1 cycle): done_o=1, pass_o=(err_cnt==0), busy_o=0 -> IDLE.
- Latency: start_i accepted at cycle 0 -> done_o high at cycle 8*LOOPS*(SETTLE_CYCLES+1)+1.
- err_cnt_o, fail_mask_o and pass_o hold after DONE until the next accepted start.

Optional Feature:
- Macro GATES_TESTER_FIRST_FAIL_EN.
- Defined:
  - Adds output first_fail_vec_o (4 bits: {valid, vec[2:0]}), capturing the vec of the first failing sample in the run.
  - Cleared on start and on reset.
- Undefined: the port and its logic are absent; no other behaviour change.

Test Plan:
- Ideal gate model, SETTLE_CYCLES=2, LOOPS=1, start at cycle 0 -> done_o pulses at cycle 25; pass_o=1, err_cnt_o=0, fail_mask_o=0x000.
- xnor output wired to xor -> err_cnt_o=8, fail_mask_o=0x020, pass_o=0; with macro, first_fail_vec_o=0x8.
- bufif0 driven 1'bz while ctrl=1, correct otherwise -> pass_o=1, since disabled bits are masked.
- buf_a stuck at 1, ERR_CNT_W=2, LOOPS=2 -> 8 failing vectors, err_cnt_o saturates at 3; fail_mask_o=0x080.
- rst_i asserted at cycle 10 of a run -> next cycle all outputs 0, state IDLE, no done_o; a new start runs a full, clean pass.
- start_i held high throughout -> runs back-to-back, one cycle of IDLE between done_o and the next busy_o; start_i is not re-accepted mid-run.

Source files
------------

// File: rtl/gates_tester.sv
// gates_tester: walks all (a,b,ctrl) vectors into a gate block and checks its 12 outputs; GATES_TESTER_FIRST_FAIL_EN adds first_fail_vec_o
module gates_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [11:0]          obs_i,
    output logic                 a_o,
    output logic                 b_o,
    output logic                 ctrl_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [11:0]          fail_mask_o
`ifdef GATES_TESTER_FIRST_FAIL_EN
    ,
    output logic [3:0]           first_fail_vec_o
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t                 state_q;
    logic [2:0]             vec_q;
    logic [7:0]             loop_q;
    logic [3:0]             cnt_q;
    logic                   busy_q, done_q, pass_q;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [11:0]            mask_q, exp_v, en, mm;
    logic                   a, b, c;
`ifdef GATES_TESTER_FIRST_FAIL_EN
    logic [3:0]             ff_q;
    assign first_fail_vec_o = ff_q;
`endif
    assign {a, b, c} = vec_q;
    assign {a_o, b_o, ctrl_o} = vec_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign pass_o = pass_q;
    assign err_cnt_o = err_q;
    assign fail_mask_o = mask_q;
    always_comb begin
        exp_v = {~a, a, ~a, a, a, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
        en = {c, c, ~c, ~c, 8'hFF};
        mm = '0;
        for (int k = 0; k < 12; k++) mm[k] = en[k] && (obs_i[k] !== exp_v[k]);
        err_d = (|mm && err_q != '1) ? err_q + 1'b1 : err_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            loop_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
`ifdef GATES_TESTER_FIRST_FAIL_EN
            ff_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    vec_q   <= '0;
                    loop_q  <= '0;
                    cnt_q   <= '0;
                    err_q   <= '0;
                    mask_q  <= '0;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= SETTLE;
`ifdef GATES_TESTER_FIRST_FAIL_EN
                    ff_q    <= '0;
`endif
                end
                SETTLE: begin
                    cnt_q   <= (cnt_q == 4'(SETTLE_CYCLES - 1)) ? 4'd0 : cnt_q + 4'd1;
                    state_q <= (cnt_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    err_q  <= err_d;
                    mask_q <= mask_q | mm;
`ifdef GATES_TESTER_FIRST_FAIL_EN
                    if (|mm && !ff_q[3]) ff_q <= {1'b1, vec_q};
`endif
                    if (vec_q == 3'd7 && loop_q == 8'(LOOPS - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        loop_q  <= loop_q + 8'(vec_q == 3'd7);
                        state_q <= SETTLE;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gates_tester.sv
// tb_gates_tester: drives two gates_tester instances from a faultable gate model and checks them against a run-level reference
module tb_gates_tester;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst0 = 1, rst1 = 1, start0 = 0, start1 = 0;
    logic a0, b0, c0, busy0, done0, pass0, a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err0, ff0, ff1;
    logic [1:0] err1;
    logic [11:0] mask0, mask1, obs0, obs1;
    int mode = 0;
    logic [11:0] flip = '0;
    logic [7:0] vmask = '0;
    logic sel = 0;
    int n_chk = 0, n_fail = 0;

    // Disabled tri-state outputs carry the opposite of their enabled value, so only masking saves them.
    function automatic logic [11:0] gate_obs(input logic a, b, c, input int m, input logic [11:0] f, input logic [7:0] vm);
        logic [11:0] o;
        o = {c ? ~a : a, c ? a : ~a, c ? a : ~a, c ? ~a : a, a, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
        if (m == 1) o[5] = a ^ b;
        if (m == 3) o[7] = 1'b1;
        if (vm[{a, b, c}]) o = o ^ f;
        return o;
    endfunction

    function automatic logic [11:0] truth(input logic a, b, c);
        logic [11:0] t;
        t[0] = a & b;   t[1] = a | b;     t[2] = a ^ b;  t[3] = ~(a & b);
        t[4] = ~(a | b); t[5] = ~(a ^ b); t[6] = ~a;     t[7] = a;
        t[8] = a;       t[9] = ~a;        t[10] = a;     t[11] = ~a;
        return t;
    endfunction

    assign obs0 = gate_obs(a0, b0, c0, mode, flip, vmask);
    assign obs1 = gate_obs(a1, b1, c1, mode, flip, vmask);

    gates_tester u0 (.clk_i(clk), .rst_i(rst0), .start_i(start0), .obs_i(obs0), .a_o(a0), .b_o(b0), .ctrl_o(c0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0), .fail_mask_o(mask0)
`ifdef GATES_TESTER_FIRST_FAIL_EN
        , .first_fail_vec_o(ff0)
`endif
    );
    gates_tester #(.SETTLE_CYCLES(1), .LOOPS(2), .ERR_CNT_W(2)) u1 (.clk_i(clk), .rst_i(rst1), .start_i(start1),
        .obs_i(obs1), .a_o(a1), .b_o(b1), .ctrl_o(c1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err1), .fail_mask_o(mask1)
`ifdef GATES_TESTER_FIRST_FAIL_EN
        , .first_fail_vec_o(ff1)
`endif
    );
`ifndef GATES_TESTER_FIRST_FAIL_EN
    assign ff0 = '0;
    assign ff1 = '0;
`endif

    wire busy_s = sel ? busy1 : busy0;
    wire done_s = sel ? done1 : done0;
    wire pass_s = sel ? pass1 : pass0;
    wire [3:0] err_s = sel ? {2'b00, err1} : err0;
    wire [11:0] mask_s = sel ? mask1 : mask0;
    wire [3:0] ff_s = sel ? ff1 : ff0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic run_case(input logic s, input int m, input logic [11:0] f, input logic [7:0] vm);
        int loops, settle, sat, cyc, ee;
        logic [11:0] em, bits;
        logic [3:0] eff;
        logic [2:0] v3;
        sel = s; mode = m; flip = f; vmask = vm;
        loops = s ? 2 : 1; settle = s ? 1 : 2; sat = s ? 3 : 15;
        ee = 0; em = '0; eff = '0;
        for (int l = 0; l < loops; l++)
            for (int v = 0; v < 8; v++) begin
                v3 = 3'(v);
                bits = (gate_obs(v3[2], v3[1], v3[0], m, f, vm) ^ truth(v3[2], v3[1], v3[0])) & (v3[0] ? 12'hCFF : 12'h3FF);
                if (bits != 0) begin
                    if (ee < sat) ee++;
                    em |= bits;
                    if (!eff[3]) eff = {1'b1, v3};
                end
            end
        @(negedge clk);
        if (s) start1 = 1; else start0 = 1;
        @(posedge clk); #1;
        start0 = 0; start1 = 0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) chk("busy_rise", 32'(busy_s), 1);
        end while (!done_s && cyc < 500);
        chk("latency", cyc, 8 * loops * (settle + 1) + 1);
        chk("pass", 32'(pass_s), 32'(ee == 0));
        chk("err_cnt", 32'(err_s), ee);
        chk("fail_mask", 32'(mask_s), 32'(em));
        chk("busy_at_done", 32'(busy_s), 0);
`ifdef GATES_TESTER_FIRST_FAIL_EN
        chk("first_fail", 32'(ff_s), 32'(eff));
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(done_s), 0);
        chk("err_hold", 32'(err_s), ee);
        chk("pass_hold", 32'(pass_s), 32'(ee == 0));
    endtask

    initial begin
        int cyc, dones;
        repeat (3) @(posedge clk);
        #1 rst0 = 0; rst1 = 0;
        @(negedge clk);
        chk("rst_u0", 32'({a0, b0, c0, busy0, done0, pass0, err0, mask0, ff0}), 0);
        chk("rst_u1", 32'({a1, b1, c1, busy1, done1, pass1, err1, mask1, ff1}), 0);
        run_case(0, 0, '0, '0);
        run_case(0, 1, '0, '0);
        run_case(1, 3, '0, '0);
        run_case(1, 0, '0, '0);
        for (int i = 0; i < 6; i++)
            run_case(1'(i), 0, ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom) & 12'($urandom), 8'($urandom));
        sel = 0; mode = 1;
        @(negedge clk); start0 = 1;
        @(posedge clk); #1 start0 = 0;
        repeat (9) @(posedge clk);
        #1 rst0 = 1;
        @(posedge clk); #1 rst0 = 0;
        @(negedge clk);
        chk("mid_rst_outs", 32'({a0, b0, c0, busy0, done0, pass0, err0, mask0, ff0}), 0);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done0) dones++; end
        chk("no_done_after_abort", dones, 0);
        chk("idle_after_abort", 32'(busy0), 0);
        run_case(0, 0, '0, '0);
        mode = 0;
        @(negedge clk); start0 = 1;
        @(posedge clk); #1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done0 && cyc < 500);
        chk("held_latency", cyc, 25);
        @(negedge clk);
        chk("held_idle_gap", 32'({busy0, done0}), 0);
        @(negedge clk);
        chk("held_restart", 32'(busy0), 1);
        start0 = 0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done0 && cyc < 500);
        chk("held_second_run", cyc, 24);
        chk("held_pass", 32'(pass0), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
